// File: rtl/game_flow_controller.sv
// Top-level game sequencer: runs the IDLE/PLAYING/VICTORY/DEFEAT/ERROR flow and the per-frame
// draw -> calc -> move -> collision -> check -> wait loop, with step watchdog and phase pacing.
module game_flow_controller #(
    parameter int MAX_PHASE_CNT = 124,
    parameter int STEP_TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       frame_end,
    input  logic       frame_start,
    input  logic       calc_done,
    input  logic       move_done,
    input  logic       coll_done,
    input  logic       player_hit,
    input  logic [3:0] enemy_alive,
    output logic [2:0] game_state,
    output logic [2:0] onplay_state,
    output logic [1:0] phase,
    output logic       draw_en,
    output logic       calc_start,
    output logic       move_start,
    output logic       coll_start,
    output logic       frame_overrun
);

    typedef enum logic [2:0] {
        GAME_IDLE    = 3'd0,
        GAME_PLAYING = 3'd1,
        GAME_VICTORY = 3'd2,
        GAME_DEFEAT  = 3'd3,
        GAME_ERROR   = 3'd4
    } game_e;

    typedef enum logic [2:0] {
        ONPLAY_DRAW      = 3'd0,
        ONPLAY_CALCVALUE = 3'd1,
        ONPLAY_MOVE      = 3'd2,
        ONPLAY_COLLISION = 3'd3,
        ONPLAY_CHECKING  = 3'd4,
        ONPLAY_WAITING   = 3'd5
    } onplay_e;

    localparam logic [6:0] PHASE_CNT_LAST = 7'(MAX_PHASE_CNT - 1);
    localparam logic [9:0] WD_LAST        = 10'(STEP_TIMEOUT - 1);

    game_e      game_r,      game_s;
    onplay_e    onplay_r,    onplay_s;
    logic [1:0] phase_r,     phase_s;
    logic [6:0] phase_cnt_r, phase_cnt_s;
    logic [9:0] wd_r,        wd_s;
    logic       calc_start_r, calc_start_s;
    logic       move_start_r, move_start_s;
    logic       coll_start_r, coll_start_s;
    logic       draw_en_r,    draw_en_s;
    logic       overrun_r,    overrun_s;
    logic       btn_q_r;
    logic       btn_rise_s;

    assign btn_rise_s = start_btn & ~btn_q_r;

    // State and registered-output update; reset drops every strobe on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            game_r       <= GAME_IDLE;
            onplay_r     <= ONPLAY_DRAW;
            phase_r      <= 2'd0;
            phase_cnt_r  <= 7'd0;
            wd_r         <= 10'd0;
            calc_start_r <= 1'b0;
            move_start_r <= 1'b0;
            coll_start_r <= 1'b0;
            draw_en_r    <= 1'b0;
            overrun_r    <= 1'b0;
            btn_q_r      <= 1'b0;
        end else begin
            game_r       <= game_s;
            onplay_r     <= onplay_s;
            phase_r      <= phase_s;
            phase_cnt_r  <= phase_cnt_s;
            wd_r         <= wd_s;
            calc_start_r <= calc_start_s;
            move_start_r <= move_start_s;
            coll_start_r <= coll_start_s;
            draw_en_r    <= draw_en_s;
            overrun_r    <= overrun_s;
            btn_q_r      <= start_btn;
        end
    end

    // Next-state and next-output logic for the game and onplay machines
    always_comb begin
        game_s       = game_r;
        onplay_s     = onplay_r;
        phase_s      = phase_r;
        phase_cnt_s  = phase_cnt_r;
        wd_s         = wd_r;
        calc_start_s = 1'b0;
        move_start_s = 1'b0;
        coll_start_s = 1'b0;
        overrun_s    = overrun_r;

        case (game_r)
            GAME_IDLE: begin
                if (btn_rise_s) begin
                    game_s      = GAME_PLAYING;
                    onplay_s    = ONPLAY_DRAW;
                    phase_s     = 2'd0;
                    phase_cnt_s = 7'd0;
                end else begin
                    game_s = GAME_IDLE;
                end
            end
            GAME_PLAYING: begin
                if (frame_end && (onplay_r != ONPLAY_DRAW)) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                // Done pulses coincident with their own strobe are stale and ignored
                case (onplay_r)
                    ONPLAY_DRAW: begin
                        if (frame_end) begin
                            onplay_s     = ONPLAY_CALCVALUE;
                            calc_start_s = 1'b1;
                            wd_s         = 10'd0;
                        end else begin
                            onplay_s = ONPLAY_DRAW;
                        end
                    end
                    ONPLAY_CALCVALUE: begin
                        if (calc_done && !calc_start_r) begin
                            onplay_s     = ONPLAY_MOVE;
                            move_start_s = 1'b1;
                            wd_s         = 10'd0;
                        end else if (wd_r == WD_LAST) begin
                            game_s = GAME_ERROR;
                        end else begin
                            wd_s = wd_r + 10'd1;
                        end
                    end
                    ONPLAY_MOVE: begin
                        if (move_done && !move_start_r) begin
                            onplay_s     = ONPLAY_COLLISION;
                            coll_start_s = 1'b1;
                            wd_s         = 10'd0;
                        end else if (wd_r == WD_LAST) begin
                            game_s = GAME_ERROR;
                        end else begin
                            wd_s = wd_r + 10'd1;
                        end
                    end
                    ONPLAY_COLLISION: begin
                        if (coll_done && !coll_start_r) begin
                            onplay_s = ONPLAY_CHECKING;
                        end else if (wd_r == WD_LAST) begin
                            game_s = GAME_ERROR;
                        end else begin
                            wd_s = wd_r + 10'd1;
                        end
                    end
                    ONPLAY_CHECKING: begin
                        if (player_hit) begin
                            game_s = GAME_DEFEAT;
                        end else if (enemy_alive == 4'd0) begin
                            game_s = GAME_VICTORY;
                        end else begin
                            onplay_s = ONPLAY_WAITING;
                            if (phase_cnt_r == PHASE_CNT_LAST) begin
                                phase_cnt_s = 7'd0;
                                phase_s     = (phase_r == 2'd3) ? 2'd3 : phase_r + 2'd1;
                            end else begin
                                phase_cnt_s = phase_cnt_r + 7'd1;
                            end
                        end
                    end
                    ONPLAY_WAITING: begin
                        if (frame_start) begin
                            onplay_s = ONPLAY_DRAW;
                        end else begin
                            onplay_s = ONPLAY_WAITING;
                        end
                    end
                    default: begin
                        game_s = GAME_ERROR;
                    end
                endcase
            end
            GAME_VICTORY, GAME_DEFEAT, GAME_ERROR: begin
                if (btn_rise_s) begin
                    game_s    = GAME_IDLE;
                    onplay_s  = ONPLAY_DRAW;
                    overrun_s = 1'b0;
                end else begin
                    game_s = game_r;
                end
            end
            default: begin
                game_s   = GAME_IDLE;
                onplay_s = ONPLAY_DRAW;
            end
        endcase

        draw_en_s = (game_s == GAME_PLAYING) && (onplay_s == ONPLAY_DRAW);
    end

    assign game_state    = game_r;
    assign onplay_state  = onplay_r;
    assign phase         = phase_r;
    assign draw_en       = draw_en_r;
    assign calc_start    = calc_start_r;
    assign move_start    = move_start_r;
    assign coll_start    = coll_start_r;
    assign frame_overrun = overrun_r;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: scoreboarded per-cycle expectations,
// a table of CHECKING decisions, and hand sequences for watchdog, overrun and reset.
module tb_game_flow_controller;

    localparam logic [2:0] G_IDLE = 3'd0, G_PLAY = 3'd1, G_VIC = 3'd2, G_DEF = 3'd3, G_ERR = 3'd4;
    localparam logic [2:0] O_DRAW = 3'd0, O_CALC = 3'd1, O_MOVE = 3'd2, O_COLL = 3'd3,
                           O_CHK = 3'd4, O_WAIT = 3'd5;

    logic       clk = 1'b0;
    logic       rst, start_btn, frame_end, frame_start;
    logic       calc_done, move_done, coll_done, player_hit;
    logic [3:0] enemy_alive;
    logic [2:0] game_state, onplay_state;
    logic [1:0] phase;
    logic       draw_en, calc_start, move_start, coll_start, frame_overrun;

    game_flow_controller dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .frame_end(frame_end),
        .frame_start(frame_start), .calc_done(calc_done), .move_done(move_done),
        .coll_done(coll_done), .player_hit(player_hit), .enemy_alive(enemy_alive),
        .game_state(game_state), .onplay_state(onplay_state), .phase(phase),
        .draw_en(draw_en), .calc_start(calc_start), .move_start(move_start),
        .coll_start(coll_start), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    typedef struct {
        logic       hit;
        logic [3:0] alive;
        logic [2:0] game;
    } vec_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         m_cnt = 0;
    logic [1:0] m_ph  = 2'd0;
    logic       m_ov  = 1'b0;

    function automatic logic [12:0] mk(logic [2:0] g, logic [2:0] o, logic [1:0] p,
                                       logic d, logic c, logic m, logic co, logic ov);
        return {g, o, p, d, c, m, co, ov};
    endfunction

    function automatic logic [12:0] obs();
        return {game_state, onplay_state, phase, draw_en, calc_start, move_start, coll_start,
                frame_overrun};
    endfunction

    // Advance one cycle; single-cycle pulse inputs drop back to 0 afterwards
    task automatic cyc();
        @(posedge clk);
        #1;
        frame_end = 1'b0; frame_start = 1'b0;
        calc_done = 1'b0; move_done = 1'b0; coll_done = 1'b0;
    endtask

    // onplay_state is only defined while PLAYING, so it is masked elsewhere
    task automatic step_exp(string tag, logic [12:0] e);
        exp_t        x;
        logic [12:0] a;
        sb.push_back('{tag, e});
        cyc();
        x = sb.pop_front();
        a = obs();
        if (x.v[12:10] != G_PLAY) begin
            a[9:7]   = 3'd0;
            x.v[9:7] = 3'd0;
        end
        total++;
        if (a !== x.v) begin
            bad++;
            $display("FAIL %s: got g/o/p/d/c/m/co/ov=%b want %b", x.tag, a, x.v);
        end
    endtask

    // One full frame loop with done pulses dly cycles after each strobe
    task automatic run_loop(int dly, logic [3:0] alive, logic hit);
        player_hit = hit; enemy_alive = alive;
        frame_end = 1'b1;
        step_exp("calc_strobe", mk(G_PLAY, O_CALC, m_ph, 1'b0, 1'b1, 1'b0, 1'b0, m_ov));
        for (int i = 0; i < dly; i++)
            step_exp("calc_wait", mk(G_PLAY, O_CALC, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
        calc_done = 1'b1;
        step_exp("move_strobe", mk(G_PLAY, O_MOVE, m_ph, 1'b0, 1'b0, 1'b1, 1'b0, m_ov));
        for (int i = 0; i < dly; i++)
            step_exp("move_wait", mk(G_PLAY, O_MOVE, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
        move_done = 1'b1;
        step_exp("coll_strobe", mk(G_PLAY, O_COLL, m_ph, 1'b0, 1'b0, 1'b0, 1'b1, m_ov));
        for (int i = 0; i < dly; i++)
            step_exp("coll_wait", mk(G_PLAY, O_COLL, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
        coll_done = 1'b1;
        step_exp("checking", mk(G_PLAY, O_CHK, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
        if (hit) begin
            step_exp("defeat", mk(G_DEF, O_CHK, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
        end else if (alive == 4'd0) begin
            step_exp("victory", mk(G_VIC, O_CHK, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
        end else begin
            m_cnt++;
            if (m_cnt == 124) begin
                m_cnt = 0;
                if (m_ph != 2'd3) m_ph = m_ph + 2'd1;
            end
            step_exp("waiting", mk(G_PLAY, O_WAIT, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
            frame_start = 1'b1;
            step_exp("redraw", mk(G_PLAY, O_DRAW, m_ph, 1'b1, 1'b0, 1'b0, 1'b0, m_ov));
        end
    endtask

    // From a terminal state: press -> IDLE, press again -> PLAYING/DRAW
    task automatic restart();
        start_btn = 1'b0;
        cyc();
        start_btn = 1'b1;
        m_ov = 1'b0;
        step_exp("to_idle", mk(G_IDLE, O_DRAW, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b0;
        cyc();
        start_btn = 1'b1;
        m_ph = 2'd0; m_cnt = 0;
        step_exp("to_play", mk(G_PLAY, O_DRAW, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b0;
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{1'b0, 4'd3,  G_PLAY};
        vt[1] = '{1'b0, 4'd15, G_PLAY};
        vt[2] = '{1'b1, 4'd0,  G_DEF};
        vt[3] = '{1'b0, 4'd0,  G_VIC};
        vt[4] = '{1'b1, 4'd7,  G_DEF};

        rst = 1'b1; start_btn = 1'b0; frame_end = 1'b0; frame_start = 1'b0;
        calc_done = 1'b0; move_done = 1'b0; coll_done = 1'b0;
        player_hit = 1'b0; enemy_alive = 4'd3;

        // Reset, then start a game; a second press while playing is ignored
        cyc(); cyc();
        step_exp("reset", mk(G_IDLE, O_DRAW, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        step_exp("idle_hold", mk(G_IDLE, O_DRAW, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b1;
        step_exp("start", mk(G_PLAY, O_DRAW, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b0;
        step_exp("draw_hold", mk(G_PLAY, O_DRAW, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b1;
        step_exp("press_in_play", mk(G_PLAY, O_DRAW, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b0;

        // One loop with 5-cycle step latency, then phase pacing
        run_loop(5, 4'd3, 1'b0);
        for (int i = 1; i < 124; i++) run_loop(1, 4'd3, 1'b0);
        total++;
        if (phase !== 2'd1) begin
            bad++;
            $display("FAIL phase_after_124: got %0d want 1", phase);
        end
        for (int i = 124; i < 496; i++) run_loop(1, 4'd3, 1'b0);
        total++;
        if (phase !== 2'd3) begin
            bad++;
            $display("FAIL phase_after_496: got %0d want 3", phase);
        end

        // CHECKING decision table
        for (int t = 0; t < 5; t++) begin
            run_loop(2, vt[t].alive, vt[t].hit);
            total++;
            if (game_state !== vt[t].game) begin
                bad++;
                $display("FAIL check_vec%0d: got %0d want %0d", t, game_state, vt[t].game);
            end
            if (vt[t].game != G_PLAY) begin
                frame_end = 1'b1;
                step_exp("terminal_hold", mk(vt[t].game, O_CHK, m_ph, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
                restart();
            end
        end

        // Withheld move_done: stale/foreign done pulses ignored, ERROR after 1023 cycles
        frame_end = 1'b1;
        step_exp("wd_calc_strobe", mk(G_PLAY, O_CALC, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        calc_done = 1'b1;
        step_exp("calc_done_on_strobe", mk(G_PLAY, O_CALC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        calc_done = 1'b1;
        step_exp("wd_move_strobe", mk(G_PLAY, O_MOVE, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 1; k <= 1023; k++) begin
            if (k == 1) move_done = 1'b1;
            if (k == 3) calc_done = 1'b1;
            if (k == 5) begin
                frame_end = 1'b1;
                m_ov = 1'b1;
            end
            if (k < 1023)
                step_exp("wd_move", mk(G_PLAY, O_MOVE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
            else
                step_exp("wd_error", mk(G_ERR, O_MOVE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_ov));
        end
        restart();

        // frame_end during CALCVALUE sets overrun; reset mid-MOVE clears everything
        frame_end = 1'b1;
        step_exp("ov_calc_strobe", mk(G_PLAY, O_CALC, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        frame_end = 1'b1;
        step_exp("ov_set", mk(G_PLAY, O_CALC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        calc_done = 1'b1;
        step_exp("ov_move_strobe", mk(G_PLAY, O_MOVE, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        step_exp("ov_move_wait", mk(G_PLAY, O_MOVE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        rst = 1'b1; move_done = 1'b1;
        step_exp("rst_mid_move", mk(G_IDLE, O_DRAW, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        total++;
        if (onplay_state !== O_DRAW) begin
            bad++;
            $display("FAIL rst_onplay: got %0d want 0", onplay_state);
        end
        rst = 1'b0;
        step_exp("post_rst", mk(G_IDLE, O_DRAW, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b1;
        step_exp("post_rst_start", mk(G_PLAY, O_DRAW, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        start_btn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
